mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative multiply/divide unit owning the HI/LO registers.
- Sits directly downstream of the register file: operands come from the two read buses (busA → a, busB → b).
- HI/LO are returned through the write-back mux to the register file write port (wd) for MFHI/MFLO.
- Executes MULT, MULTU, DIV and DIVU in a fixed 33-cycle sequence. Supports MTHI/MTLO direct writes.

Parameters:
- WIDTH, 32, operand and HI/LO width. Only 32 is supported; counter width is 5 bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  launch request; sampled only while busy=0.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  32  operand A: multiplicand or dividend, from busA.
- b  in  32  operand B: multiplier or divisor, from busB.
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  32  MTHI/MTLO data.
- busy  out  1  operation in progress.
- done  out  1  single-cycle completion pulse.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, internal datapath registers cleared. Reset takes effect immediately, including mid-operation; the aborted result is discarded and no done pulse is produced.
- States: IDLE, CALC, FIX. busy = (state != IDLE), decoded from registered state.
- IDLE, edge T0 with start=1:
  - Latch op. Latch |a| and |b| (two's-complement magnitude for signed ops when the sign bit is set; raw value for unsigned ops).
  - Record sign_q = a[31]^b[31] and sign_r = a[31] (signed ops only; both 0 for unsigned).
  - Counter=0. Go to CALC.
- CALC, edges T1..T32, one iteration per edge:
  - Multiply: shift-add on a 64-bit accumulator, consuming one multiplier bit per edge, LSB first.
  - Divide: restoring, one quotient bit per edge, MSB first. Trial subtract of the divisor from the 33-bit partial remainder; keep the difference if non-negative.
  - Counter increments each edge. At the edge where counter==31, go to FIX.
- FIX, edge T33:
  - Apply sign correction. Product: negate the 64-bit result if sign_q. Divide: negate quotient if sign_q, negate remainder if sign_r.
  - Write hi/lo: multiply → {hi,lo}=product; divide → lo=quotient, hi=remainder.
  - done=1 for exactly one cycle (T33..T34). Go to IDLE.
- Timing: busy is high from after T0 until T33. Results are visible on hi/lo from T33. Latency is 33 cycles start-to-done, and a new start is accepted at T33 at the earliest.
- Divisor zero (DIV or DIVU): run the full 33 cycles. Result is lo=32'hFFFFFFFF and hi=a as presented at T0. No trap.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of 32-bit magnitude wrap and is not special-cased.
- start while busy: ignored; not queued.
- hi_we/lo_we in IDLE: hi/lo ← wdata at that edge. Both may be set together.
- hi_we/lo_we while busy: dropped.
- start together with hi_we/lo_we in IDLE: the write is applied at T0 and the operation proceeds; the result overwrites hi/lo at T33.
- Operand stability: a and b need only be stable at T0.
- hi and lo hold their value between writes and are never X after reset.

Test Plan:
- Reset mid-op:
  - MULTU a=5, b=7, pulse rst_n low at T10 → busy=0 and hi=lo=0 immediately.
  - Restart the same op → hi=0, lo=35 at T33, with done high for exactly one cycle.
- Signed multiply: MULT a=0xFFFFFFFD (-3), b=7 → T33: hi=0xFFFFFFFF, lo=0xFFFFFFEB. busy high exactly 33 cycles.
- Unsigned multiply: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- Signed divide: DIV a=-7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- Divide boundaries:
  - DIVU a=100, b=0 → lo=0xFFFFFFFF, hi=100.
  - DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Back-to-back and MTHI/MTLO:
  - Launch DIVU 100/7, then assert start with MULTU operands at T5 and hi_we=1 (wdata=0xAAAA) at T10 → both ignored; T33 gives lo=14, hi=2.
  - start at T33 is accepted.
  - In IDLE, lo_we with wdata=0x1234 → lo=0x1234 next cycle.

Source files
------------

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative 32-bit multiply/divide unit owning HI/LO
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t           state, nstate;
  logic [4:0]       cnt;
  logic [1:0]       op_q;
  logic             sign_q, sign_r, bzero;
  logic [WIDTH-1:0] opnd;      // multiplicand (mul) or divisor (div) magnitude
  logic [WIDTH-1:0] acc_hi;    // upper product half / partial remainder
  logic [WIDTH-1:0] acc_lo;    // multiplier bits / dividend bits -> quotient
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;
  logic             fix_en;

  // op[0]=0 marks the signed variants, op[1]=1 marks divide
  logic             is_signed, is_div;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   dshift;
  logic             dge;
  logic [WIDTH-1:0] ddiff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // operand magnitudes and one iteration of the shift-add / restoring-divide datapath
  always_comb begin
    is_signed = ~op[0];
    is_div    = op[1];
    a_mag     = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    b_mag     = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
    msum      = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    dshift    = {acc_hi, acc_lo[WIDTH-1]};
    dge       = (dshift >= {1'b0, opnd});
    ddiff     = dshift[WIDTH-1:0] - opnd;
    prod      = {acc_hi, acc_lo};
    prod_fix  = sign_q ? (~prod + 1'b1) : prod;
    // a zero divisor keeps the all-ones quotient regardless of sign
    quo_fix   = (sign_q && !bzero) ? (~acc_lo + 1'b1) : acc_lo;
    rem_fix   = sign_r ? (~acc_hi + 1'b1) : acc_hi;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  // next-state: launch on start, 32 iterations, one fix-up cycle
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start) nstate = CALC;
      CALC:    if (cnt == 5'd31) nstate = FIX;
      FIX:     nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    busy   = (state != IDLE);
    fix_en = (state == FIX);
  end

  // datapath, HI/LO and the registered done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      op_q   <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      bzero  <= 1'b0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= fix_en;
      case (state)
        IDLE: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start) begin
            op_q   <= op;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= is_div ? a_mag : b_mag;
            opnd   <= is_div ? b_mag : a_mag;
            sign_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            sign_r <= is_signed & a[WIDTH-1];
            bzero  <= (b == '0);
          end
        end
        CALC: begin
          cnt <= cnt + 5'd1;
          if (op_q[1]) begin
            acc_hi <= dge ? ddiff : dshift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], dge};
          end else begin
            acc_hi <= msum[WIDTH:1];
            acc_lo <= {msum[0], acc_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (op_q[1]) begin
            lo_q <= quo_fix;
            hi_q <= rem_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - directed self-checking bench for mdu_iter
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // waits (bounded) for done after the launch edge; counts busy samples on the way
  task automatic wait_done(output int cyc, output int bcnt);
    cyc = 0;
    bcnt = 0;
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
    int cyc, bcnt;
    launch(o, x, y);
    wait_done(cyc, bcnt);
    check({tag, "_lat"}, 64'(cyc), 64'd33);
    check({tag, "_busy"}, 64'(bcnt), 64'd33);
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, ehi});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, elo});
    @(posedge clk); #1;
    check({tag, "_done1"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int cyc, bcnt;
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset mid-operation
    launch(MULTU, 32'd5, 32'd7);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_done", {63'd0, done}, 64'd0);
    run_op("multu5x7", MULTU, 32'd5, 32'd7, 32'd0, 32'd35);

    run_op("mult_neg", MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_zero", DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    run_op("div_zero", DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("multu_big", MULTU, 32'h1234_5678, 32'h0000_1000, 32'h0000_0123, 32'h4567_8000);

    // start and MTHI while busy are dropped
    launch(DIVU, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1 begin op = MULTU; a = 32'd3; b = 32'd3; start = 1'b1; end
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 begin hi_we = 1'b1; wdata = 32'h0000_AAAA; end
    @(posedge clk); #1 hi_we = 1'b0;
    wait_done(cyc, bcnt);
    check("b2b_lat", 64'(cyc + 10), 64'd33);
    check("b2b_hi", {32'd0, hi}, 64'd2);
    check("b2b_lo", {32'd0, lo}, 64'd14);

    // start presented in the done cycle is accepted
    op = MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("restart_busy", {63'd0, busy}, 64'd1);
    wait_done(cyc, bcnt);
    check("restart_lat", 64'(cyc), 64'd33);
    check("restart_lo", {32'd0, lo}, 64'd42);

    // MTLO / MTHI in idle
    @(posedge clk); #1;
    lo_we = 1'b1; wdata = 32'h0000_1234;
    @(posedge clk); #1 lo_we = 1'b0;
    check("mtlo", {32'd0, lo}, 64'h1234);
    check("mtlo_hi_kept", {32'd0, hi}, 64'd0);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555_0000;
    @(posedge clk); #1 begin hi_we = 1'b0; lo_we = 1'b0; end
    check("mthilo", {hi, lo}, 64'h5555_0000_5555_0000);

    // write together with start: write lands at T0, result overwrites at T33
    op = MULT; a = 32'd2; b = 32'hFFFF_FFFF; start = 1'b1; hi_we = 1'b1; wdata = 32'h0000_0777;
    @(posedge clk); #1 begin start = 1'b0; hi_we = 1'b0; end
    check("wr_start_hi", {32'd0, hi}, 64'h777);
    wait_done(cyc, bcnt);
    check("wr_start_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
